// File: rtl/axi_ic_pkg.sv
// Shared definitions for the AXI interconnect return paths.
// Contents: slave count, slave index type, R-arbiter state enum, RRESP codes.
package axi_ic_pkg;

  localparam int unsigned NUM_SLAVES = 4;

  typedef logic [1:0] slave_idx_t;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_BURST = 1'b1
  } r_arb_state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/rr_arbiter_4.sv
// Combinational 4-way round-robin pick: first asserted req searching upward
// from ptr, wrapping 3->0. Shared by the R and B return paths.
// Ports:
//   req       in   4  request vector
//   ptr       in   2  highest-priority index
//   gnt_idx   out  2  selected index (ptr when nothing requests)
//   gnt_valid out  1  at least one request present
module rr_arbiter_4
  import axi_ic_pkg::*;
(
  input  logic [NUM_SLAVES-1:0] req,
  input  slave_idx_t            ptr,
  output slave_idx_t            gnt_idx,
  output logic                  gnt_valid
);

  slave_idx_t w_idx;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = ptr;
    w_idx     = ptr;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      w_idx = ptr + slave_idx_t'(k);
      if (req[w_idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = w_idx;
      end
    end
  end

endmodule

// File: rtl/axi_r_return_arbiter_4x1.sv
// AXI R-channel return arbiter: merges 4 slave R channels onto one master
// R channel. Round-robin grant per burst, held until the RLAST handshake,
// so beats of different slaves never interleave. No buffering: payload and
// RREADY are combinational pass-through while a burst is granted.
// Optional build macro R_STALL_TIMEOUT_EN adds a sticky timeout_err output
// raised when the granted slave withholds RVALID for TIMEOUT_CYCLES cycles.
// Ports:
//   ACLK, ARESETN         clock, synchronous active-low reset
//   S_RDATA/RID/RRESP     packed slave payloads, slave i at slice i
//   S_RLAST/S_RVALID      per-slave, S_RREADY per-slave ready out
//   M_R*                  master R channel, M_RREADY in
//   timeout_err           (R_STALL_TIMEOUT_EN only) sticky stall error
module axi_r_return_arbiter_4x1
  import axi_ic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ID_WIDTH       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                             ACLK,
  input  logic                             ARESETN,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] S_RDATA,
  input  logic [NUM_SLAVES*ID_WIDTH-1:0]   S_RID,
  input  logic [2*NUM_SLAVES-1:0]          S_RRESP,
  input  logic [NUM_SLAVES-1:0]            S_RLAST,
  input  logic [NUM_SLAVES-1:0]            S_RVALID,
  output logic [NUM_SLAVES-1:0]            S_RREADY,
  output logic [DATA_WIDTH-1:0]            M_RDATA,
  output logic [ID_WIDTH-1:0]              M_RID,
  output logic [1:0]                       M_RRESP,
  output logic                             M_RLAST,
  output logic                             M_RVALID,
  input  logic                             M_RREADY
`ifdef R_STALL_TIMEOUT_EN
  ,
  output logic                             timeout_err
`endif
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  r_arb_state_e r_state, w_state_nxt;
  slave_idx_t   r_grant, w_grant_nxt;
  slave_idx_t   r_ptr, w_ptr_nxt;
  slave_idx_t   w_arb_idx;
  logic         w_arb_valid;

  rr_arbiter_4 u_rr (
    .req       (S_RVALID),
    .ptr       (r_ptr),
    .gnt_idx   (w_arb_idx),
    .gnt_valid (w_arb_valid)
  );

  // State, grant and round-robin pointer registers.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state <= R_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Next-state and pass-through mux; everything is zero outside BURST.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    M_RDATA     = '0;
    M_RID       = '0;
    M_RRESP     = '0;
    M_RLAST     = 1'b0;
    M_RVALID    = 1'b0;
    S_RREADY    = '0;
    case (r_state)
      R_IDLE: begin
        if (w_arb_valid) begin
          w_grant_nxt = w_arb_idx;
          w_state_nxt = R_BURST;
        end
      end
      R_BURST: begin
        M_RDATA           = S_RDATA[r_grant*DATA_WIDTH +: DATA_WIDTH];
        M_RID             = S_RID[r_grant*ID_WIDTH +: ID_WIDTH];
        M_RRESP           = S_RRESP[r_grant*2 +: 2];
        M_RLAST           = S_RLAST[r_grant];
        M_RVALID          = S_RVALID[r_grant];
        S_RREADY[r_grant] = M_RREADY;
        if (S_RVALID[r_grant] && M_RREADY && S_RLAST[r_grant]) begin
          w_state_nxt = R_IDLE;
          w_ptr_nxt   = r_grant + slave_idx_t'(1);
        end
      end
      default: w_state_nxt = R_IDLE;
    endcase
  end

`ifdef R_STALL_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_timeout_err;
  logic             w_stall;

  assign w_stall     = (r_state == R_BURST) && !S_RVALID[r_grant];
  assign timeout_err = r_timeout_err;

  // Stall counter restarts whenever the granted slave presents a beat or
  // the arbiter is idle, so every burst starts from zero. Saturates.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_stall_cnt   <= '0;
      r_timeout_err <= 1'b0;
    end else if (w_stall) begin
      if (r_stall_cnt != CNT_W'(TIMEOUT_CYCLES))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (r_stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1))
        r_timeout_err <= 1'b1;
    end else begin
      r_stall_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_axi_r_return_arbiter_4x1.sv
// Directed bench for axi_r_return_arbiter_4x1 with simple per-slave
// beat sources; expected beats and RREADY masks are written out by hand.
module tb_axi_r_return_arbiter_4x1;
  import axi_ic_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned IW = 4;

  logic            ACLK = 1'b0;
  logic            ARESETN;
  logic [4*DW-1:0] S_RDATA;
  logic [4*IW-1:0] S_RID;
  logic [7:0]      S_RRESP;
  logic [3:0]      S_RLAST;
  logic [3:0]      S_RVALID;
  logic [3:0]      S_RREADY;
  logic [DW-1:0]   M_RDATA;
  logic [IW-1:0]   M_RID;
  logic [1:0]      M_RRESP;
  logic            M_RLAST;
  logic            M_RVALID;
  logic            M_RREADY;
`ifdef R_STALL_TIMEOUT_EN
  logic            timeout_err;
`endif

  always #5 ACLK = ~ACLK;

  axi_r_return_arbiter_4x1 #(
    .DATA_WIDTH     (DW),
    .ID_WIDTH       (IW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .ACLK     (ACLK),
    .ARESETN  (ARESETN),
    .S_RDATA  (S_RDATA),
    .S_RID    (S_RID),
    .S_RRESP  (S_RRESP),
    .S_RLAST  (S_RLAST),
    .S_RVALID (S_RVALID),
    .S_RREADY (S_RREADY),
    .M_RDATA  (M_RDATA),
    .M_RID    (M_RID),
    .M_RRESP  (M_RRESP),
    .M_RLAST  (M_RLAST),
    .M_RVALID (M_RVALID),
    .M_RREADY (M_RREADY)
`ifdef R_STALL_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Slave source state: beats remaining, beat number, burst length.
  int          rem [4];
  int          bn  [4];
  int          blen[4];
  logic [DW-1:0] base[4];
  logic [IW-1:0] rid [4];
  logic [1:0]    resp[4];
  logic          hold[4];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      S_RVALID[i]          = (rem[i] > 0) && !hold[i];
      S_RDATA[i*DW +: DW]  = (rem[i] > 0) ? base[i] + DW'(bn[i]) : '0;
      S_RLAST[i]           = (rem[i] > 0) && ((bn[i] % blen[i]) == blen[i] - 1);
      S_RID[i*IW +: IW]    = rid[i];
      S_RRESP[i*2 +: 2]    = resp[i];
    end
  endtask

  task automatic load(input int i, input int n, input int bl, input logic [DW-1:0] b,
                      input logic [IW-1:0] id, input logic [1:0] rs);
    rem[i] = n; bn[i] = 0; blen[i] = bl; base[i] = b; rid[i] = id; resp[i] = rs;
    hold[i] = 1'b0;
    drive();
  endtask

  // Called at the negedge: latch handshakes, cross the posedge, step sources.
  task automatic advance();
    logic [3:0] hs;
    hs = S_RVALID & S_RREADY;
    @(posedge ACLK);
    #1;
    for (int i = 0; i < 4; i++)
      if (hs[i]) begin
        bn[i]++;
        rem[i]--;
      end
    drive();
  endtask

  task automatic expect_idle(input string tag);
    @(negedge ACLK);
    check({tag, "_vld"}, 64'(M_RVALID), 64'd0);
    check({tag, "_rdy"}, 64'(S_RREADY), 64'd0);
    check({tag, "_dat"}, 64'(M_RDATA),  64'd0);
    advance();
  endtask

  task automatic expect_beat(input string tag, input logic rdy, input logic [DW-1:0] data,
                             input logic [IW-1:0] id, input logic [1:0] rs,
                             input logic last, input logic [3:0] mask);
    M_RREADY = rdy;
    @(negedge ACLK);
    check({tag, "_vld"},  64'(M_RVALID), 64'd1);
    check({tag, "_dat"},  64'(M_RDATA),  64'(data));
    check({tag, "_id"},   64'(M_RID),    64'(id));
    check({tag, "_resp"}, 64'(M_RRESP),  64'(rs));
    check({tag, "_last"}, 64'(M_RLAST),  64'(last));
    check({tag, "_rdy"},  64'(S_RREADY), 64'(mask));
    advance();
  endtask

  initial begin
    int order[5];
    logic [3:0] rdy_seq;
    ARESETN  = 1'b0;
    M_RREADY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rem[i] = 0; bn[i] = 0; blen[i] = 1; base[i] = '0; rid[i] = '0;
      resp[i] = OKAY; hold[i] = 1'b0;
    end
    drive();
    repeat (2) @(posedge ACLK);
    #1;
    @(negedge ACLK);
    check("rst_vld", 64'(M_RVALID), 64'd0);
    check("rst_rdy", 64'(S_RREADY), 64'd0);
    check("rst_dat", 64'(M_RDATA),  64'd0);
`ifdef R_STALL_TIMEOUT_EN
    check("rst_terr", 64'(timeout_err), 64'd0);
`endif
    @(posedge ACLK);
    #1;
    ARESETN  = 1'b1;
    M_RREADY = 1'b1;

    // Slave 2, 4-beat burst, one arbitration cycle then back-to-back beats.
    load(2, 4, 4, 32'hA0, 4'd5, OKAY);
    expect_idle("t1_arb");
    for (int k = 0; k < 4; k++)
      expect_beat("t1_beat", 1'b1, 32'hA0 + DW'(k), 4'd5, OKAY, k == 3, 4'b0100);
    expect_idle("t1_end");

    // rr_ptr is now 3: slave 3 beats slave 0, then slave 0 follows.
    load(0, 1, 1, 32'h10, 4'd1, OKAY);
    load(3, 1, 1, 32'h30, 4'd3, OKAY);
    expect_idle("tp_arb");
    expect_beat("tp_s3", 1'b1, 32'h30, 4'd3, OKAY, 1'b1, 4'b1000);
    expect_idle("tp_gap");
    expect_beat("tp_s0", 1'b1, 32'h10, 4'd1, OKAY, 1'b1, 4'b0001);
    expect_idle("tp_end");

    // Slave 1, 3 beats with M_RREADY toggling; stalled beats repeat.
    load(1, 3, 3, 32'hB0, 4'd3, OKAY);
    expect_idle("t3_arb");
    expect_beat("t3_b0",  1'b1, 32'hB0, 4'd3, OKAY, 1'b0, 4'b0010);
    expect_beat("t3_b1s", 1'b0, 32'hB1, 4'd3, OKAY, 1'b0, 4'b0000);
    expect_beat("t3_b1",  1'b1, 32'hB1, 4'd3, OKAY, 1'b0, 4'b0010);
    expect_beat("t3_b2s", 1'b0, 32'hB2, 4'd3, OKAY, 1'b1, 4'b0000);
    expect_beat("t3_b2",  1'b1, 32'hB2, 4'd3, OKAY, 1'b1, 4'b0010);
    expect_idle("t3_end");

    // Reset mid-burst from slave 3; re-arbitration restarts at slave 0.
    load(3, 8, 8, 32'hD0, 4'd7, OKAY);
    expect_idle("t4_arb");
    expect_beat("t4_b0", 1'b1, 32'hD0, 4'd7, OKAY, 1'b0, 4'b1000);
    expect_beat("t4_b1", 1'b1, 32'hD1, 4'd7, OKAY, 1'b0, 4'b1000);
    ARESETN = 1'b0;
    @(negedge ACLK);
    advance();
    ARESETN = 1'b1;
    load(0, 1, 1, 32'h55, 4'd2, OKAY);
    expect_idle("t4_rst");
    expect_beat("t4_s0", 1'b1, 32'h55, 4'd2, OKAY, 1'b1, 4'b0001);
    expect_idle("t4_gap");
    for (int k = 3; k < 8; k++)
      expect_beat("t4_s3", 1'b1, 32'hD0 + DW'(k), 4'd7, OKAY, k == 7, 4'b1000);
    expect_idle("t4_end");

    // All four requesting, 2-beat bursts: grant order 0,1,2,3,0.
    order = '{0, 1, 2, 3, 0};
    load(0, 4, 2, 32'h100, 4'd8, OKAY);
    for (int i = 1; i < 4; i++)
      load(i, 2, 2, 32'h100 + DW'(i * 16), IW'(8 + i), OKAY);
    expect_idle("t2_arb");
    for (int j = 0; j < 5; j++) begin
      int s, off;
      s   = order[j];
      off = (j == 4) ? 2 : 0;
      for (int k = 0; k < 2; k++)
        expect_beat("t2_beat", 1'b1, 32'h100 + DW'(s * 16 + off + k), IW'(8 + s), OKAY,
                    k == 1, 4'(1 << s));
      expect_idle("t2_gap");
    end

    // Single-beat SLVERR bursts from slaves 0 and 1; rr_ptr is 1 here.
    load(0, 2, 1, 32'h60, 4'd1, SLVERR);
    load(1, 2, 1, 32'h70, 4'd2, SLVERR);
    expect_idle("t5_arb");
    expect_beat("t5_s1a", 1'b1, 32'h70, 4'd2, SLVERR, 1'b1, 4'b0010);
    expect_idle("t5_g1");
    expect_beat("t5_s0a", 1'b1, 32'h60, 4'd1, SLVERR, 1'b1, 4'b0001);
    expect_idle("t5_g2");
    expect_beat("t5_s1b", 1'b1, 32'h71, 4'd2, SLVERR, 1'b1, 4'b0010);
    expect_idle("t5_g3");
    expect_beat("t5_s0b", 1'b1, 32'h61, 4'd1, SLVERR, 1'b1, 4'b0001);
    expect_idle("t5_end");

    // Granted slave 0 gaps for 10 cycles: grant held, RREADY still routed.
    load(0, 3, 3, 32'hE0, 4'd4, OKAY);
    expect_idle("t6_arb");
    expect_beat("t6_b0", 1'b1, 32'hE0, 4'd4, OKAY, 1'b0, 4'b0001);
    hold[0] = 1'b1;
    drive();
    for (int k = 1; k <= 10; k++) begin
      @(negedge ACLK);
      check("t6_gap_vld", 64'(M_RVALID), 64'd0);
      check("t6_gap_rdy", 64'(S_RREADY), 64'd1);
`ifdef R_STALL_TIMEOUT_EN
      if (k == 8) check("t6_terr_pre",  64'(timeout_err), 64'd0);
      if (k == 9) check("t6_terr_post", 64'(timeout_err), 64'd1);
`endif
      advance();
    end
    hold[0] = 1'b0;
    drive();
    expect_beat("t6_b1", 1'b1, 32'hE1, 4'd4, OKAY, 1'b0, 4'b0001);
    expect_beat("t6_b2", 1'b1, 32'hE2, 4'd4, OKAY, 1'b1, 4'b0001);
`ifdef R_STALL_TIMEOUT_EN
    @(negedge ACLK);
    check("t6_terr_sticky", 64'(timeout_err), 64'd1);
    advance();
`endif
    expect_idle("t6_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
